instr_ram_arbiter: RTL and testbench
====================================

INSTR_RAM_ARBITER -- requirements
Module: instr_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 18: word-address bus width, including the MSB boot-ROM select bit.
REQ-002 Parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-003 Parameter MAX_WAIT, default 8: maximum consecutive stalled cycles for the debug port before it is force-granted; legal range 1..255.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: the single clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Core port, inputs: core_req_i (1), core_addr_i (ADDR_WIDTH). Outputs: core_gnt_o (1), core_rvalid_o (1), core_rdata_o (DATA_WIDTH). This port is read-only instruction fetch.
REQ-008 Debug/loader port, inputs: dbg_req_i (1), dbg_addr_i (ADDR_WIDTH), dbg_we_i (1), dbg_be_i (DATA_WIDTH/8), dbg_wdata_i (DATA_WIDTH), dbg_lock_i (1). Outputs: dbg_gnt_o (1), dbg_rvalid_o (1), dbg_rdata_o (DATA_WIDTH).
REQ-009 Memory port, outputs: mem_en_o (1), mem_addr_o (ADDR_WIDTH), mem_we_o (1), mem_be_o (DATA_WIDTH/8), mem_wdata_o (DATA_WIDTH). Input: mem_rdata_i (DATA_WIDTH), valid exactly one cycle after mem_en_o.

Function
REQ-010 Grants are combinational in the request cycle; a transfer occurs in every cycle where req and gnt are both high.
REQ-011 At most one grant is high per cycle. mem_en_o = core_gnt_o | dbg_gnt_o.
REQ-012 Default priority: the core wins when both ports request and the override conditions below are false.
REQ-013 Override: the debug port wins over the core while dbg_lock_i = 1 or wait_cnt_q = MAX_WAIT.
REQ-014 While dbg_lock_i = 1, core_gnt_o is 0 even when dbg_req_i = 0.
REQ-015 wait_cnt_q increments in each cycle with dbg_req_i & ~dbg_gnt_o, saturates at MAX_WAIT, and clears in any cycle with dbg_gnt_o or ~dbg_req_i.
REQ-016 Memory mux: mem_addr/we/be/wdata come from the granted port. A core grant drives mem_we_o = 0 and mem_be_o = all ones. With no grant, all mem outputs are 0.
REQ-017 Owner register owner_q ∈ {OWN_NONE, OWN_CORE, OWN_DBG} loads the granted port each cycle, or OWN_NONE if none was granted.
REQ-018 core_rvalid_o = (owner_q == OWN_CORE); dbg_rvalid_o = (owner_q == OWN_DBG).
REQ-019 Writes also produce dbg_rvalid_o one cycle after the grant.
REQ-020 core_rdata_o and dbg_rdata_o both carry mem_rdata_i unmodified; the data is meaningful only with the corresponding rvalid.
REQ-021 Back-to-back transfers from either port or alternating ports at full rate (one per cycle) are supported with no bubble.
REQ-022 Requests to addresses with the MSB set (boot ROM) are arbitrated identically; the arbiter does not decode addresses.

Reset
REQ-023 While rst_n = 0: owner_q = OWN_NONE, wait_cnt_q = 0, both rvalid outputs = 0.
REQ-024 Grant and mem outputs remain purely a function of the inputs and wait_cnt_q during reset. A transfer completing in the reset-assertion cycle returns no rvalid.

Structure
REQ-025 Package instr_ram_arb_pkg holds the owner_t enum (OWN_NONE, OWN_CORE, OWN_DBG).
REQ-026 The package also holds the WAIT_CNT_W = 8 constant.
REQ-027 Single module; no sub-module. Grant logic is one combinational block; owner_q and wait_cnt_q are the only state.

Verification
REQ-028 Core-only stream: core_req held high for 4 cycles with addrs 0x0, 0x1, 0x2, 0x3 -> 4 grants, rvalid on cycles 1-4, rdata matches the memory model.
REQ-029 Continuous contention, MAX_WAIT = 8: both ports requesting -> core granted cycles 0-7, dbg granted cycle 8, core granted cycle 9, pattern repeats every 9 cycles.
REQ-030 dbg_lock_i = 1 with core_req high for 10 cycles -> core_gnt_o is 0 throughout; a dbg write to 0x10 of 0xDEADBEEF, be = 0xF, is granted immediately with dbg_rvalid_o next cycle; a later core read of 0x10 returns 0xDEADBEEF.
REQ-031 Alternating single-cycle requests core, dbg, core -> each is granted in its own cycle with no stall; rvalid is routed to the correct port each following cycle.
REQ-032 rst_n asserted in the cycle after a dbg grant -> dbg_rvalid_o is 0; after release, wait_cnt_q = 0 and the first contended cycle grants the core.
REQ-033 Boot address 0x20000 requested by the core -> mem_addr_o = 0x20000 and the grant behaves as for any other address.

Source files
------------

// File: rtl/instr_ram_arb_pkg.sv
// Shared types for the instruction RAM arbiter: grant owner encoding and wait counter width.
package instr_ram_arb_pkg;

    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

endpackage

// File: rtl/instr_ram_arbiter.sv
// Two-port arbiter (core fetch, debug/loader) in front of a single-port instruction RAM.
// Latency: grant combinational in request cycle, rvalid/rdata one cycle after grant.
// Backpressure: core has priority; debug wins under lock or after MAX_WAIT stalled cycles.
module instr_ram_arbiter
    import instr_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    core_req_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,

    input  logic                    dbg_req_i,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr_i,
    input  logic                    dbg_we_i,
    input  logic [DATA_WIDTH/8-1:0] dbg_be_i,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
    input  logic                    dbg_lock_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dbg_rdata_o,

    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_SAT = WAIT_CNT_W'(MAX_WAIT);

    owner_t                owner_q, owner_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  dbg_wins;

    always_comb begin
        dbg_wins    = dbg_lock_i | (wait_cnt_q == WAIT_SAT);
        // Lock starves the core even when the debug port is idle.
        core_gnt_o  = core_req_i & ~dbg_lock_i & ~(dbg_req_i & dbg_wins);
        dbg_gnt_o   = dbg_req_i & ~core_gnt_o;
        mem_en_o    = core_gnt_o | dbg_gnt_o;

        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        owner_d     = OWN_NONE;
        if (core_gnt_o) begin
            mem_addr_o = core_addr_i;
            mem_be_o   = '1;
            owner_d    = OWN_CORE;
        end else if (dbg_gnt_o) begin
            mem_addr_o  = dbg_addr_i;
            mem_we_o    = dbg_we_i;
            mem_be_o    = dbg_be_i;
            mem_wdata_o = dbg_wdata_i;
            owner_d     = OWN_DBG;
        end

        wait_cnt_d = '0;
        if (dbg_req_i && !dbg_gnt_o) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign core_rvalid_o = (owner_q == OWN_CORE);
    assign dbg_rvalid_o  = (owner_q == OWN_DBG);
    assign core_rdata_o  = mem_rdata_i;
    assign dbg_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed bench for instr_ram_arbiter: grants checked per cycle, read responses via scoreboard queues.
module tb_instr_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_i;
    logic [17:0] core_addr_i;
    logic        core_gnt_o, core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        dbg_req_i;
    logic [17:0] dbg_addr_i;
    logic        dbg_we_i;
    logic [3:0]  dbg_be_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_lock_i;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        mem_en_o;
    logic [17:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;

    instr_ram_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_we_i(dbg_we_i),
        .dbg_be_i(dbg_be_i), .dbg_wdata_i(dbg_wdata_i), .dbg_lock_i(dbg_lock_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        logic        chk_dat;
    } exp_t;
    exp_t core_q[$];
    exp_t dbg_q[$];

    // Memory contents: every word starts as 0x5A000000 | address.
    logic [31:0] mem [0:1023];

    function automatic logic [31:0] init_val(input logic [17:0] a);
        return 32'h5A00_0000 | {14'h0, a};
    endfunction

    function automatic logic [9:0] idx(input logic [17:0] a);
        return {a[17], a[8:0]};
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] iv;
            iv = i[9:0];
            mem[i] = init_val({iv[9], 8'h00, iv[8:0]});
        end
    end

    always @(posedge clk) begin
        if (mem_en_o) begin
            mem_rdata_i <= mem[idx(mem_addr_o)];
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) mem[idx(mem_addr_o)][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: each expected response must appear exactly in its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (core_q.size() > 0 && core_q[0].cyc == cyc) begin
            e = core_q.pop_front();
            chk("core_rvalid", 32'(core_rvalid_o), 32'd1);
            if (e.chk_dat) chk("core_rdata", core_rdata_o, e.dat);
        end else if (core_rvalid_o) begin
            chk("core_rvalid_spurious", 32'(core_rvalid_o), 32'd0);
        end
        if (dbg_q.size() > 0 && dbg_q[0].cyc == cyc) begin
            e = dbg_q.pop_front();
            chk("dbg_rvalid", 32'(dbg_rvalid_o), 32'd1);
            if (e.chk_dat) chk("dbg_rdata", dbg_rdata_o, e.dat);
        end else if (dbg_rvalid_o) begin
            chk("dbg_rvalid_spurious", 32'(dbg_rvalid_o), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // mode: 0 = expect response without data check, 1 = check data, 2 = no response expected
    task automatic step(input logic cr, input logic [17:0] ca,
                        input logic dr, input logic [17:0] da, input logic dw,
                        input logic [3:0] db, input logic [31:0] dd, input logic dl,
                        input logic ecg, input logic edg, input logic [31:0] ed, input int mode);
        exp_t e;
        core_req_i = cr; core_addr_i = ca;
        dbg_req_i = dr; dbg_addr_i = da; dbg_we_i = dw; dbg_be_i = db;
        dbg_wdata_i = dd; dbg_lock_i = dl;
        @(negedge clk);
        chk("core_gnt", 32'(core_gnt_o), 32'(ecg));
        chk("dbg_gnt", 32'(dbg_gnt_o), 32'(edg));
        chk("mem_en", 32'(mem_en_o), 32'(ecg | edg));
        if (ecg) begin
            chk("mem_addr_core", 32'(mem_addr_o), 32'(ca));
            chk("mem_we_core", 32'(mem_we_o), 32'd0);
            chk("mem_be_core", 32'(mem_be_o), 32'hF);
        end else if (edg) begin
            chk("mem_addr_dbg", 32'(mem_addr_o), 32'(da));
            chk("mem_we_dbg", 32'(mem_we_o), 32'(dw));
            chk("mem_be_dbg", 32'(mem_be_o), 32'(db));
            if (dw) chk("mem_wdata_dbg", mem_wdata_o, dd);
        end else begin
            chk("mem_addr_idle", 32'(mem_addr_o), 32'd0);
            chk("mem_we_idle", 32'(mem_we_o), 32'd0);
            chk("mem_be_idle", 32'(mem_be_o), 32'd0);
        end
        if (mode != 2 && (ecg || edg)) begin
            e.cyc = cyc + 1;
            e.dat = ed;
            e.chk_dat = (mode == 1);
            if (ecg) core_q.push_back(e);
            else     dbg_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle();
        step(1'b0, 18'h0, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2);
    endtask

    // Reset asserted right after a clock edge; responses from that edge must be suppressed.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
            chk("rst_dbg_rvalid", 32'(dbg_rvalid_o), 32'd0);
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic contend(input int n, input logic [31:0] dbg_pat, input int last_mode);
        for (int i = 0; i < n; i++) begin
            logic is_dbg;
            logic [17:0] ca;
            is_dbg = dbg_pat[i];
            ca = 18'h40 + 18'(i);
            step(1'b1, ca, 1'b1, 18'h80, 1'b0, 4'hF, 32'h0, 1'b0,
                 ~is_dbg, is_dbg, is_dbg ? init_val(18'h80) : init_val(ca),
                 (i == n - 1) ? last_mode : 1);
        end
    endtask

    initial begin
        logic [31:0] pat19;
        logic [31:0] pat9;
        rst_n = 1'b0;
        core_req_i = 1'b0; core_addr_i = '0;
        dbg_req_i = 1'b0; dbg_addr_i = '0; dbg_we_i = 1'b0; dbg_be_i = '0;
        dbg_wdata_i = '0; dbg_lock_i = 1'b0;

        // Reset state, and grants stay combinational during reset.
        @(negedge clk);
        chk("reset_core_rvalid", 32'(core_rvalid_o), 32'd0);
        chk("reset_dbg_rvalid", 32'(dbg_rvalid_o), 32'd0);
        chk("reset_mem_en", 32'(mem_en_o), 32'd0);
        core_req_i = 1'b1; core_addr_i = 18'h33;
        #1;
        chk("reset_core_gnt", 32'(core_gnt_o), 32'd1);
        chk("reset_mem_addr", 32'(mem_addr_o), 32'h33);
        @(posedge clk);
        #1;
        core_req_i = 1'b0;
        rst_n = 1'b1;

        // Core-only stream.
        for (int i = 0; i < 4; i++)
            step(1'b1, 18'(i), 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b0,
                 1'b1, 1'b0, init_val(18'(i)), 1);
        idle();

        // Continuous contention: debug wins every 9th cycle.
        pat19 = 32'b000_0000_0000_0010_0000_0001_0000_0000;
        contend(19, pat19, 1);
        idle();

        // Lock: core starved, debug write granted immediately.
        for (int i = 0; i < 10; i++) begin
            if (i == 4)
                step(1'b1, 18'h10, 1'b1, 18'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1,
                     1'b0, 1'b1, 32'h0, 0);
            else if (i == 6)
                step(1'b1, 18'h10, 1'b1, 18'h11, 1'b1, 4'h3, 32'h1234_5678, 1'b1,
                     1'b0, 1'b1, 32'h0, 0);
            else
                step(1'b1, 18'h10, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h0, 2);
        end
        idle();
        step(1'b1, 18'h10, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1);
        step(1'b1, 18'h11, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5A00_5678, 1);
        idle();

        // Alternating ports at full rate.
        step(1'b1, 18'h5, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5A00_0005, 1);
        step(1'b0, 18'h0, 1'b1, 18'h6, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5A00_0006, 1);
        step(1'b1, 18'h7, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5A00_0007, 1);
        idle();

        // Boot ROM address is arbitrated like any other.
        step(1'b1, 18'h20000, 1'b1, 18'h80, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5A02_0000, 1);
        idle();

        // Reset right after a debug grant suppresses its rvalid.
        step(1'b0, 18'h0, 1'b1, 18'h9, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 2);
        do_reset(2);
        idle();

        // Reset after partial starvation clears the wait counter.
        pat9 = 32'h0;
        contend(5, pat9, 2);
        do_reset(1);
        pat9 = 32'h0000_0100;
        contend(9, pat9, 1);
        idle();
        idle();

        chk("core_q_drained", 32'(core_q.size()), 32'd0);
        chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
